// File: rtl/inst_queue.sv
// Instruction prefetch queue: circular FIFO of {pc, inst} pairs between fetch and decode,
// with a synchronous flush used on branch/jump redirects.
module inst_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              push;
    logic              pop;

    // Flow control derives from occupancy only; a full queue never passes through.
    always_comb begin
        in_ready  = (cnt_q != CNT_W'(DEPTH));
        out_valid = (cnt_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        count     = cnt_q;
        out_pc    = '0;
        out_inst  = '0;
        if (out_valid) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end
    end

    // Pointer and occupancy state; reset beats flush, flush discards any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Entry storage is not reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

endmodule
